// File: rtl/enemy_pkg.sv
// Shared types and per-enemy patrol segment constants for the enemy patrol block.
// Enemy i (0-based) in the arrays below is enemy i+1 at the top level.
package enemy_pkg;

  typedef enum logic [2:0] {FWD, REV, PAUSE_F, PAUSE_R, HALT} patrol_state_t;
  typedef enum logic {AXIS_H, AXIS_V} axis_t;

  localparam int NUM_ENEMIES = 5;

  // Bit i set means enemy i+1 moves vertically.
  localparam logic [NUM_ENEMIES-1:0] ENEMY_AXIS = 5'b01010;
  localparam logic [0:NUM_ENEMIES-1][9:0] ENEMY_FIXED = {10'd96,  10'd496, 10'd288, 10'd624, 10'd448};
  localparam logic [0:NUM_ENEMIES-1][9:0] ENEMY_MIN   = {10'd208, 10'd64,  10'd336, 10'd160, 10'd176};
  localparam logic [0:NUM_ENEMIES-1][9:0] ENEMY_MAX   = {10'd400, 10'd256, 10'd656, 10'd448, 10'd528};

  function automatic logic [19:0] pack_position(axis_t axis, logic [9:0] fixed, logic [9:0] moving);
    return (axis == AXIS_H) ? {moving, fixed} : {fixed, moving};
  endfunction

endpackage

// File: rtl/enemy_patroller.sv
// One enemy walking a fixed segment: steps on tick, pauses at each end,
// swaps direction on a reverse pulse, and freezes for good on halt.
module enemy_patroller
  import enemy_pkg::*;
#(
  parameter axis_t      AXIS        = AXIS_H,
  parameter logic [9:0] FIXED       = 10'd0,
  parameter logic [9:0] MIN         = 10'd0,
  parameter logic [9:0] MAX         = 10'd16,
  parameter int         STEP        = 2,
  parameter int         PAUSE_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        reverse,
  input  logic        halt,
  output logic [19:0] position
);

  localparam int PW = $clog2(PAUSE_TICKS + 1);
  localparam logic [9:0]    STEP_W     = 10'(STEP);
  localparam logic [PW-1:0] PAUSE_INIT = PW'(PAUSE_TICKS);

  patrol_state_t state, state_next;
  logic [9:0]    pos, pos_next;
  logic [PW-1:0] pause, pause_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FWD;
      pos   <= MIN;
      pause <= '0;
    end else begin
      state <= state_next;
      pos   <= pos_next;
      pause <= pause_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_next = state;
    pos_next   = pos;
    pause_next = pause;
    if (halt) begin
      state_next = HALT;
    end else begin
      unique case (state)
        FWD: begin
          if (reverse) state_next = REV;
          else if (tick) begin
            if (pos + STEP_W >= MAX) begin
              pos_next   = MAX;
              pause_next = PAUSE_INIT;
              state_next = PAUSE_F;
            end else begin
              pos_next = pos + STEP_W;
            end
          end
        end
        REV: begin
          if (reverse) state_next = FWD;
          else if (tick) begin
            if (pos <= MIN + STEP_W) begin
              pos_next   = MIN;
              pause_next = PAUSE_INIT;
              state_next = PAUSE_R;
            end else begin
              pos_next = pos - STEP_W;
            end
          end
        end
        PAUSE_F, PAUSE_R: begin
          if (tick) begin
            pause_next = pause - PW'(1);
            if (pause == PW'(1)) state_next = (state == PAUSE_F) ? REV : FWD;
          end
        end
        HALT: ;
        default: state_next = FWD;
      endcase
    end
  end

  always_comb begin
    position = pack_position(AXIS, FIXED, pos);
  end

endmodule

// File: rtl/enemy_patrol.sv
// Five patrolling enemies sharing one movement tick, a hit edge detector
// that reverses the named enemy, and a sticky win halt.
module enemy_patrol
  import enemy_pkg::*;
#(
  parameter int TICK_DIV    = 250000,
  parameter int STEP        = 2,
  parameter int PAUSE_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        win,
  input  logic        hit,
  input  logic [2:0]  hit_id,
  output logic [19:0] e_position1,
  output logic [19:0] e_position2,
  output logic [19:0] e_position3,
  output logic [19:0] e_position4,
  output logic [19:0] e_position5,
  output logic        halted
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;
  logic          tick;
  logic          hit_q;
  logic          hit_rise;
  logic [NUM_ENEMIES-1:0]       reverse;
  logic [NUM_ENEMIES-1:0][19:0] positions;

  assign tick     = enable && (count == CNT_LAST);
  assign hit_rise = hit && !hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      hit_q  <= 1'b0;
      halted <= 1'b0;
    end else begin
      hit_q  <= hit;
      halted <= halted | win;
      if (enable) count <= tick ? '0 : count + CW'(1);
    end
  end

  // Ids 0, 6 and 7 match no enemy and are dropped here.
  always_comb begin
    reverse = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      reverse[i] = hit_rise && (hit_id == 3'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_enemy
    enemy_patroller #(
      .AXIS        (axis_t'(ENEMY_AXIS[g])),
      .FIXED       (ENEMY_FIXED[g]),
      .MIN         (ENEMY_MIN[g]),
      .MAX         (ENEMY_MAX[g]),
      .STEP        (STEP),
      .PAUSE_TICKS (PAUSE_TICKS)
    ) u_patroller (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .reverse  (reverse[g]),
      .halt     (win),
      .position (positions[g])
    );
  end

  assign e_position1 = positions[0];
  assign e_position2 = positions[1];
  assign e_position3 = positions[2];
  assign e_position4 = positions[3];
  assign e_position5 = positions[4];

endmodule

// File: tb/tb_enemy_patrol.sv
// Self-checking bench for enemy_patrol: per-cycle scoreboard against a behavioural
// model, a table of hand-derived position checkpoints, and directed corner sequences.
module tb_enemy_patrol;

  localparam int TICK_DIV    = 4;
  localparam int STEP        = 2;
  localparam int PAUSE_TICKS = 2;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        enable = 1'b0;
  logic        win    = 1'b0;
  logic        hit    = 1'b0;
  logic [2:0]  hit_id = 3'd0;
  logic [19:0] e_position1, e_position2, e_position3, e_position4, e_position5;
  logic        halted;

  enemy_patrol #(
    .TICK_DIV    (TICK_DIV),
    .STEP        (STEP),
    .PAUSE_TICKS (PAUSE_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .win         (win),
    .hit         (hit),
    .hit_id      (hit_id),
    .e_position1 (e_position1),
    .e_position2 (e_position2),
    .e_position3 (e_position3),
    .e_position4 (e_position4),
    .e_position5 (e_position5),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][19:0] pos;
    logic             halted;
  } expect_t;

  typedef struct {
    int cycles;
    bit en;
    bit h;
    int id;
    int enemy;
    int exp_h;
    int exp_v;
  } vec_t;

  expect_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Segment geometry: axis 0 = horizontal, 1 = vertical.
  int seg_axis  [5] = '{0, 1, 0, 1, 0};
  int seg_fixed [5] = '{96, 496, 288, 624, 448};
  int seg_min   [5] = '{208, 64, 336, 160, 176};
  int seg_max   [5] = '{400, 256, 656, 448, 528};

  // Model state codes: 0 forward, 1 reverse, 2 pause at max, 3 pause at min, 4 halted.
  int m_pos [5];
  int m_st  [5];
  int m_pause [5];
  int m_cnt;
  bit m_hq;
  bit m_halted;

  // Checkpoints from reset with enable held high; ticks land on every 4th edge.
  vec_t vecs [12] = '{
    '{0,   1, 0, 0, 1, 208, 96},
    '{0,   1, 0, 0, 4, 624, 160},
    '{3,   1, 0, 0, 1, 208, 96},
    '{1,   1, 0, 0, 1, 210, 96},
    '{0,   1, 0, 0, 2, 496, 66},
    '{380, 1, 0, 0, 1, 400, 96},
    '{1,   1, 1, 1, 1, 400, 96},
    '{7,   1, 0, 0, 1, 400, 96},
    '{4,   1, 0, 0, 1, 398, 96},
    '{380, 1, 0, 0, 1, 208, 96},
    '{8,   1, 0, 0, 1, 208, 96},
    '{4,   1, 0, 0, 1, 210, 96}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%05h (%0d/%0d) expected 0x%05h (%0d/%0d)",
               name, act, act[19:10], act[9:0], exp, exp[19:10], exp[9:0]);
    end
  endtask

  function automatic logic [19:0] hv(input int h, input int v);
    return {10'(h), 10'(v)};
  endfunction

  function automatic logic [19:0] model_word(input int i);
    if (seg_axis[i] == 0) return {10'(m_pos[i]), 10'(seg_fixed[i])};
    return {10'(seg_fixed[i]), 10'(m_pos[i])};
  endfunction

  function automatic logic [19:0] dut_pos(input int k);
    case (k)
      1: return e_position1;
      2: return e_position2;
      3: return e_position3;
      4: return e_position4;
      default: return e_position5;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_pos[i]   = seg_min[i];
      m_st[i]    = 0;
      m_pause[i] = 0;
    end
    m_cnt    = 0;
    m_hq     = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit w, input bit h, input int id);
    bit tk;
    bit rise;
    tk   = en && (m_cnt == TICK_DIV - 1);
    rise = h && !m_hq;
    for (int i = 0; i < 5; i++) begin
      if (w) m_st[i] = 4;
      else case (m_st[i])
        0: if (rise && id == i + 1) m_st[i] = 1;
           else if (tk) begin
             if (m_pos[i] + STEP >= seg_max[i]) begin
               m_pos[i] = seg_max[i]; m_pause[i] = PAUSE_TICKS; m_st[i] = 2;
             end else m_pos[i] += STEP;
           end
        1: if (rise && id == i + 1) m_st[i] = 0;
           else if (tk) begin
             if (m_pos[i] <= seg_min[i] + STEP) begin
               m_pos[i] = seg_min[i]; m_pause[i] = PAUSE_TICKS; m_st[i] = 3;
             end else m_pos[i] -= STEP;
           end
        2, 3: if (tk) begin
             m_pause[i]--;
             if (m_pause[i] == 0) m_st[i] = (m_st[i] == 2) ? 1 : 0;
           end
        default: ;
      endcase
    end
    if (w) m_halted = 1'b1;
    m_hq = h;
    if (en) m_cnt = tk ? 0 : m_cnt + 1;
  endtask

  // Drive one cycle from a negedge, predict, then compare at the following negedge.
  task automatic cycle(input bit en, input bit w, input bit h, input int id);
    expect_t e;
    enable = en; win = w; hit = h; hit_id = 3'(id);
    model_edge(en, w, h, id);
    for (int i = 0; i < 5; i++) e.pos[i] = model_word(i);
    e.halted = m_halted;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: queue empty, expected an entry");
    end else begin
      e = sb_q.pop_front();
      for (int k = 1; k <= 5; k++) check($sformatf("sb e_position%0d t=%0t", k, $time), dut_pos(k), e.pos[k-1]);
      check($sformatf("sb halted t=%0t", $time), halted, e.halted);
    end
  endtask

  // Called at a negedge: asserts reset between edges and checks outputs before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; win = 1'b0; hit = 1'b0; hit_id = 3'd0;
    #2;
    check("reset e_position1", e_position1, hv(208, 96));
    check("reset e_position2", e_position2, hv(496, 64));
    check("reset e_position3", e_position3, hv(336, 288));
    check("reset e_position4", e_position4, hv(624, 160));
    check("reset e_position5", e_position5, hv(176, 448));
    check("reset halted", halted, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    for (int n = 0; n < 12; n++) begin
      for (int c = 0; c < vecs[n].cycles; c++) cycle(vecs[n].en, 1'b0, vecs[n].h, vecs[n].id);
      check($sformatf("vec%0d e_position%0d", n, vecs[n].enemy), dut_pos(vecs[n].enemy),
            hv(vecs[n].exp_h, vecs[n].exp_v));
    end

    // Single-cycle hit on E2 mid-segment.
    do_reset();
    repeat (72) cycle(1, 0, 0, 0);
    check("e2 before hit", e_position2, hv(496, 100));
    cycle(1, 0, 1, 2);
    repeat (3) cycle(1, 0, 0, 0);
    check("e2 after reversal", e_position2, hv(496, 98));
    check("e1 unaffected", e_position1, hv(246, 96));
    check("e3 unaffected", e_position3, hv(374, 288));
    check("e4 unaffected", e_position4, hv(624, 198));
    check("e5 unaffected", e_position5, hv(214, 448));

    // Long hit on E3 reverses once; ids 0 and 7 do nothing.
    repeat (40) cycle(1, 0, 1, 3);
    check("e3 held hit", e_position3, hv(354, 288));
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 7);
    cycle(1, 0, 0, 0);
    check("e1 after bad ids", e_position1, hv(268, 96));
    check("e3 after bad ids", e_position3, hv(352, 288));
    check("e2 after bad ids", e_position2, hv(496, 76));

    // Hit rising on a tick edge: reversal wins, no step.
    repeat (2) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 1);
    check("e1 hit on tick", e_position1, hv(268, 96));
    repeat (4) cycle(1, 0, 0, 0);
    check("e1 step after tick hit", e_position1, hv(266, 96));

    // Enable low mid-count holds the divider.
    cycle(1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    check("e1 enable low", e_position1, hv(266, 96));
    repeat (2) cycle(1, 0, 0, 0);
    check("e1 count resumed", e_position1, hv(266, 96));
    cycle(1, 0, 0, 0);
    check("e1 tick after resume", e_position1, hv(264, 96));

    // Win halts permanently.
    cycle(1, 1, 0, 0);
    check("halted after win", halted, 1'b1);
    repeat (50) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 1);
    repeat (49) cycle(1, 0, 0, 0);
    check("e1 frozen", e_position1, hv(264, 96));
    check("halted sticky", halted, 1'b1);

    // Asynchronous reset during an end pause.
    do_reset();
    repeat (386) cycle(1, 0, 0, 0);
    check("e1 in pause", e_position1, hv(400, 96));
    do_reset();
    repeat (4) cycle(1, 0, 0, 0);
    check("e1 first step after reset", e_position1, hv(210, 96));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
